// File: rtl/life_engine.sv
// life_engine: row-serial Conway B3/S23 stepper with optional toroidal edges and per-step statistics
module life_engine #(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int GEN_W = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               wrap,
  input  logic [ROWS*COLS-1:0]               board_i,
  output logic [ROWS*COLS-1:0]               board_o,
  output logic                               busy,
  output logic                               done,
  output logic [GEN_W-1:0]                   gen_count,
  output logic [$clog2(ROWS*COLS+1)-1:0]     pop_count,
  output logic [$clog2(ROWS*COLS+1)-1:0]     birth_count
);
  localparam int N = ROWS * COLS;
  localparam int CW = $clog2(N + 1);
  localparam int RW = $clog2(ROWS);
  typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;
  state_t state;
  logic [N-1:0] snap, nxt;
  logic wrap_r;
  logic [RW-1:0] row;
  logic [CW-1:0] pop_acc, birth_acc, row_pop, row_birth;
  logic [COLS-1:0] row_next;
  // Evaluate the current row from the snapshot only; neighbours never see freshly computed rows
  always_comb begin
    int rr, cc;
    logic [3:0] n;
    logic alive, nv;
    row_next = '0;
    row_pop = '0;
    row_birth = '0;
    for (int c = 0; c < COLS; c++) begin
      n = '0;
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++)
          if (dr != 0 || dc != 0) begin
            rr = int'(row) + dr;
            cc = c + dc;
            if (wrap_r) begin
              rr = rr < 0 ? rr + ROWS : rr >= ROWS ? rr - ROWS : rr;
              cc = cc < 0 ? cc + COLS : cc >= COLS ? cc - COLS : cc;
            end
            if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
              n = n + 4'(snap[rr*COLS+cc]);
          end
      alive = snap[int'(row)*COLS+c];
      nv = (n == 4'd3) | (alive & (n == 4'd2));
      row_next[c] = nv;
      row_pop = row_pop + CW'(nv);
      row_birth = row_birth + CW'(nv & ~alive);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      snap <= '0;
      nxt <= '0;
      wrap_r <= 1'b0;
      row <= '0;
      pop_acc <= '0;
      birth_acc <= '0;
      board_o <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      gen_count <= '0;
      pop_count <= '0;
      birth_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          snap <= board_i;
          wrap_r <= wrap;
          row <= '0;
          pop_acc <= '0;
          birth_acc <= '0;
          busy <= 1'b1;
          state <= COMPUTE;
        end
        COMPUTE: begin
          nxt[int'(row)*COLS +: COLS] <= row_next;
          pop_acc <= pop_acc + row_pop;
          birth_acc <= birth_acc + row_birth;
          row <= row + 1'b1;
          if (row == RW'(ROWS - 1)) state <= COMMIT;
        end
        COMMIT: begin
          board_o <= nxt;
          pop_count <= pop_acc;
          birth_count <= birth_acc;
          gen_count <= gen_count + 1'b1;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: directed and random steps checked against an array-based Game of Life model
module tb_life_engine;
  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int N = ROWS * COLS;
  localparam int CW = $clog2(N + 1);
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic wrap = 1'b0;
  logic [N-1:0] board_i = '0;
  logic [N-1:0] board_o;
  logic busy, done;
  logic [15:0] gen_count;
  logic [CW-1:0] pop_count, birth_count;
  logic start2 = 1'b0;
  logic [N-1:0] board2 = '0;
  logic [N-1:0] board_o2;
  logic busy2, done2;
  logic [1:0] gen2;
  logic [CW-1:0] pop2, birth2;
  int compared = 0;
  int mismatched = 0;
  int exp_gen = 0;
  life_engine #(.ROWS(ROWS), .COLS(COLS), .GEN_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .wrap(wrap), .board_i(board_i),
    .board_o(board_o), .busy(busy), .done(done), .gen_count(gen_count),
    .pop_count(pop_count), .birth_count(birth_count));
  life_engine #(.ROWS(ROWS), .COLS(COLS), .GEN_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .wrap(wrap), .board_i(board2),
    .board_o(board_o2), .busy(busy2), .done(done2), .gen_count(gen2),
    .pop_count(pop2), .birth_count(birth2));
  always #5 clk = ~clk;

  function automatic logic [N-1:0] cl(input int r, input int c);
    logic [N-1:0] b = '0;
    b[r*COLS+c] = 1'b1;
    return b;
  endfunction

  function automatic logic [N-1:0] rnd_board();
    logic [N-1:0] b;
    for (int i = 0; i < N / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // Reference: count live neighbours on a 2-D grid, modulo arithmetic when wrapping
  function automatic logic [N-1:0] life_next(input logic [N-1:0] b, input logic w);
    logic [N-1:0] nb = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        int cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            int rr = r + dr;
            int cc = c + dc;
            if (w) begin
              rr = (rr + ROWS) % ROWS;
              cc = (cc + COLS) % COLS;
            end
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
              cnt += int'(b[rr*COLS+cc]);
          end
        nb[r*COLS+c] = (cnt == 3) || (b[r*COLS+c] && cnt == 2);
      end
    return nb;
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_gen = 0;
  endtask

  task automatic step(input logic [N-1:0] b, input logic w);
    logic [N-1:0] exp, prev;
    int cnt;
    exp = life_next(b, w);
    prev = board_o;
    @(negedge clk);
    board_i = b;
    wrap = w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    board_i = ~b;
    wrap = ~w;
    chk("busy_after_start", N'(busy), N'(1));
    cnt = 1;
    while (!done && cnt < 40) begin
      chk("board_hold", board_o, prev);
      @(negedge clk);
      cnt++;
    end
    chk("latency", N'(cnt), N'(ROWS + 2));
    chk("board", board_o, exp);
    chk("pop", N'(pop_count), N'($countones(exp)));
    chk("birth", N'(birth_count), N'($countones(exp & ~b)));
    exp_gen++;
    chk("gen", N'(gen_count), N'(exp_gen & 16'hffff));
    @(negedge clk);
    chk("done_single", N'(done), N'(0));
    chk("busy_idle", N'(busy), N'(0));
  endtask

  initial begin
    logic [N-1:0] b1, b2, exp, blk;
    int dones;
    do_reset();
    chk("rst_board", board_o, '0);
    chk("rst_gen", N'(gen_count), '0);
    chk("rst_pop", N'(pop_count), '0);
    chk("rst_birth", N'(birth_count), '0);
    chk("rst_busy", N'(busy), '0);
    chk("rst_done", N'(done), '0);
    // blinker, dead boundary
    step(cl(7, 6) | cl(7, 7) | cl(7, 8), 1'b0);
    chk("blinker", board_o, cl(6, 7) | cl(7, 7) | cl(8, 7));
    chk("blinker_pop", N'(pop_count), N'(3));
    chk("blinker_birth", N'(birth_count), N'(2));
    // vertical blinker straddling the top/bottom edge
    b1 = cl(0, 15) | cl(1, 15) | cl(15, 15);
    step(b1, 1'b1);
    chk("edge_wrap", board_o, cl(0, 14) | cl(0, 15) | cl(0, 0));
    step(b1, 1'b0);
    chk("edge_nowrap", board_o, '0);
    chk("edge_nowrap_pop", N'(pop_count), '0);
    // still life
    do_reset();
    blk = cl(3, 3) | cl(3, 4) | cl(4, 3) | cl(4, 4);
    for (int i = 0; i < 5; i++) begin
      step(blk, 1'b0);
      chk("still", board_o, blk);
      chk("still_pop", N'(pop_count), N'(4));
    end
    chk("still_gen", N'(gen_count), N'(5));
    // start while busy is ignored
    b1 = rnd_board();
    b2 = rnd_board();
    exp = life_next(b1, 1'b0);
    @(negedge clk);
    board_i = b1;
    wrap = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    board_i = b2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    exp_gen++;
    chk("busy_start_dones", N'(dones), N'(1));
    chk("busy_start_board", board_o, exp);
    chk("busy_start_gen", N'(gen_count), N'(exp_gen));
    // reset lands on edge k+8 of a step
    @(negedge clk);
    board_i = rnd_board();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_gen = 0;
    chk("midrst_board", board_o, '0);
    chk("midrst_gen", N'(gen_count), '0);
    chk("midrst_pop", N'(pop_count), '0);
    chk("midrst_birth", N'(birth_count), '0);
    chk("midrst_busy", N'(busy), '0);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("midrst_nodone", N'(dones), '0);
    step(rnd_board(), 1'b1);
    chk("midrst_gen1", N'(gen_count), N'(1));
    // random boards and edge modes
    for (int i = 0; i < 20; i++) step(rnd_board() & rnd_board(), 1'($urandom_range(0, 1)));
    // 2-bit generation counter wraps
    for (int i = 1; i <= 4; i++) begin
      int cnt;
      @(negedge clk) start2 = 1'b1;
      @(negedge clk) start2 = 1'b0;
      cnt = 1;
      while (!done2 && cnt < 40) begin
        @(negedge clk);
        cnt++;
      end
      chk("gw_done", N'(done2), N'(1));
      chk("gw_gen", N'(gen2), N'(i % 4));
      chk("gw_pop", N'(pop2), '0);
      chk("gw_birth", N'(birth2), '0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/life_engine.md
LIFE_ENGINE -- requirements
Module: life_engine

Interface
REQ-001 The module SHALL have parameter ROWS, default 16, meaning board height in cells (>=3).
REQ-002 The module SHALL have parameter COLS, default 16, meaning board width in cells (>=3).
REQ-003 The module SHALL have parameter GEN_W, default 16, meaning generation counter width.
REQ-004 The module SHALL have port clk  input  1  rising-edge clock; sole clock domain.
REQ-005 The module SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 The module SHALL have port start  input  1  request one generation step from board_i.
REQ-007 The module SHALL have port wrap  input  1  1 = toroidal edges, 0 = dead boundary; sampled with start.
REQ-008 The module SHALL have port board_i  input  ROWS*COLS  seed board; cell (r,c) at bit r*COLS+c.
REQ-009 The module SHALL have port board_o  output  ROWS*COLS  last committed generation, same indexing.
REQ-010 The module SHALL have port busy  output  1  high while a step is in progress.
REQ-011 The module SHALL have port done  output  1  one-cycle pulse on commit.
REQ-012 The module SHALL have port gen_count  output  GEN_W  committed generations since reset.
REQ-013 The module SHALL have port pop_count  output  clog2(ROWS*COLS+1)  live cells in board_o.
REQ-014 The module SHALL have port birth_count  output  clog2(ROWS*COLS+1)  dead->live cells in last step.

Function
REQ-015 FSM states SHALL be IDLE, COMPUTE, COMMIT; reset state IDLE.
REQ-016 In IDLE with start=1 at edge k: snapshot board_i and wrap into internal registers, clear the row index, go to COMPUTE.
REQ-017 COMPUTE SHALL evaluate exactly one row per cycle, rows 0..ROWS-1 on edges k+1..k+ROWS, writing a next-state buffer; board_o SHALL remain unchanged during COMPUTE.
REQ-018 After row ROWS-1 the FSM SHALL enter COMMIT; at edge k+ROWS+1, copy the buffer to board_o, update counters, return to IDLE.
REQ-019 done SHALL be 1 for exactly the cycle following the COMMIT edge; otherwise 0.
REQ-020 busy SHALL be 1 in COMPUTE and COMMIT, 0 in IDLE.
REQ-021 start SHALL be ignored while busy=1; no queuing.
REQ-022 Each cell SHALL count its 8 neighbours (count 0..8, 4-bit) from the snapshot only, never from partially computed results.
REQ-023 wrap=1: neighbour row/column indices SHALL be taken modulo ROWS/COLS.
REQ-024 wrap=0: out-of-range neighbours SHALL count as dead.
REQ-025 Rule B3/S23: live with 2 or 3 neighbours stays live; dead with exactly 3 neighbours becomes live; all others dead.
REQ-026 pop_count SHALL equal the number of 1s in the new board_o at commit.
REQ-027 birth_count SHALL equal the number of cells 0 in the snapshot and 1 in the new board.
REQ-028 gen_count SHALL increment by 1 per commit and wrap from 2^GEN_W-1 to 0.
REQ-029 Counts SHALL be accumulated per row during COMPUTE; no combinational sum across the full board in a single cycle.
REQ-030 start and reset=0 in the same cycle: reset SHALL win.

Reset
REQ-031 When reset=0 at a clock edge: state IDLE; board_o, gen_count, pop_count, birth_count, done, busy, and internal buffers all 0.
REQ-032 Reset mid-COMPUTE or COMMIT SHALL abort the step with no commit and no done pulse.
REQ-033 First start after reset release SHALL behave as in REQ-016.

Verification
REQ-034 Blinker: 16x16 board, cells (7,6),(7,7),(7,8), wrap=0, start -> done at edge k+17; board_o = cells (6,7),(7,7),(8,7); pop=3; birth=2; gen=1.
REQ-035 Edge wrap: cells (0,15),(1,15),(15,15) (vertical blinker across the wrap edge), wrap=1 -> board_o = (0,14),(0,15),(0,0); with wrap=0 -> board_o = (0,15) dead, pop=0.
REQ-036 Still life: 2x2 block at (3,3)-(4,4), 5 consecutive steps -> board_o unchanged each step, birth=0, pop=4, gen=5.
REQ-037 Start while busy: pulse start at edges k and k+5 -> only one done pulse; gen increments by 1.
REQ-038 Reset mid-step: reset=0 at edge k+8 -> no done pulse; all outputs 0; a subsequent start completes normally with gen=1.
REQ-039 Gen wrap: GEN_W=2, 4 steps on an empty board -> gen sequence 1,2,3,0; pop=0; birth=0.
